bf2_stage_ctrl: RTL and testbench

//  Sequencer for one radix-2 SDF butterfly stage (BF2I bundle + D-cycle delay buffer) in the streaming FFT.

---
 rtl/bf2_stage_ctrl.sv | 184 ++++++++++++++++++
 tb/tb_bf2_stage_ctrl.sv | 391 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bf2_stage_ctrl.sv
// ----------------------------------------------------------------------------
// bf2_stage_ctrl
//   Sequencer for one radix-2 SDF butterfly stage (BF2I + D-beat delay buffer)
//   in the streaming FFT. A frame is CPF = N_POINT/LANES beats. The first D
//   beats of a stream only fill the delay buffer. After that, the stage
//   alternates between two kinds of D-beat blocks. In a phase-1 block the
//   butterfly fires and the add result goes out. In a phase-0 block the buffered
//   sub results from the previous phase-1 block go out. At end of stream the
//   buffer is drained with D internal beats.
//
// Parameters
//   N_POINT      FFT length (power of two)
//   LANES        samples per beat; CPF = N_POINT/LANES (power of two, >= 2)
//   STAGE_SHIFT  butterfly distance D = 2**STAGE_SHIFT beats, 0..CW-1
//
// Ports
//   clk         rising-edge clock
//   rstn        asynchronous active-low reset
//   din_valid   input beat present
//   din_sop     input beat is sample 0 of a frame
//   din_ready   input beat accepted when din_valid & din_ready
//   bf_en       butterfly add/sub registered this cycle
//   buf_sel     1: delay buffer loads sub results, 0: loads raw input
//   cyc_cnt     beat index within the current frame (flush index in FLUSH)
//   dout_valid  stage output beat valid (one cycle after the producing beat)
//   dout_sop    first output beat of a frame
//   err_sop     one-cycle pulse on a misplaced or missing sop
//   frame_cnt   completed frames, wrapping   (only with FFT_CTRL_STAT_EN)
//   err_cnt     err_sop count, saturating    (only with FFT_CTRL_STAT_EN)
//   state_dbg   FSM state: 0 IDLE, 1 FILL, 2 RUN, 3 FLUSH
//
// Handshake: a beat transfers on a cycle where din_valid & din_ready are both
// high. din_ready is low in FLUSH. It is also low on the stream-boundary cycle
// where din_valid is already low. That cycle is the first flush beat, so
// lowering ready there never refuses a beat.
//
// Optional feature macro: FFT_CTRL_STAT_EN (adds frame_cnt / err_cnt).
// ----------------------------------------------------------------------------
module bf2_stage_ctrl #(
    parameter int N_POINT     = 512,
    parameter int LANES       = 16,
    parameter int STAGE_SHIFT = 3,
    localparam int CPF        = N_POINT / LANES,
    localparam int CW         = $clog2(CPF)
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          din_valid,
    input  logic          din_sop,
    output logic          din_ready,
    output logic          bf_en,
    output logic          buf_sel,
    output logic [CW-1:0] cyc_cnt,
    output logic          dout_valid,
    output logic          dout_sop,
    output logic          err_sop,
`ifdef FFT_CTRL_STAT_EN
    output logic [15:0]   frame_cnt,
    output logic [7:0]    err_cnt,
`endif
    output logic [1:0]    state_dbg
);

    localparam int D = 1 << STAGE_SHIFT;
    localparam logic [CW-1:0] CNT_ONE = CW'(1);
    localparam logic [CW-1:0] D_IDX   = CW'(D);
    localparam logic [CW-1:0] D_LAST  = CW'(D - 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_FILL  = 2'd1;
    localparam logic [1:0] S_RUN   = 2'd2;
    localparam logic [1:0] S_FLUSH = 2'd3;

    logic [1:0]    state;
    logic [1:0]    state_nxt;
    logic [CW-1:0] cnt_nxt;

    logic acc;
    logic at_wrap;
    logic phase;
    logic resync;
    logic miss_sop;
    logic edge_flush;
    logic run_beat;
    logic flush_beat;

    // In RUN, cyc_cnt == 0 only occurs right after a frame wrapped. The beat
    // seen there decides between back-to-back continuation and stream end.
    assign at_wrap    = (state == S_RUN) && (cyc_cnt == '0);
    assign edge_flush = at_wrap && !din_valid;
    assign din_ready  = (state != S_FLUSH) && !edge_flush;
    assign acc        = din_valid && din_ready;
    assign phase      = cyc_cnt[STAGE_SHIFT];

    assign resync     = (state == S_RUN) && acc && din_sop && !at_wrap;
    assign miss_sop   = at_wrap && acc && !din_sop;
    assign run_beat   = (state == S_RUN) && acc && !resync && !miss_sop;
    // The boundary cycle (idle or missing sop) is itself flush beat 0. This
    // keeps the drain contiguous with the last frame's output.
    assign flush_beat = (state == S_FLUSH) || edge_flush || miss_sop;

    assign bf_en      = run_beat && phase;
    // A resync beat is beat 0 of a new frame and must load raw input.
    assign buf_sel    = (state == S_RUN) && phase && !resync;
    assign state_dbg  = state;

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cyc_cnt;
        case (state)
            S_IDLE: begin
                if (acc && din_sop) begin
                    cnt_nxt   = CNT_ONE;
                    state_nxt = (D == 1) ? S_RUN : S_FILL;
                end
            end
            S_FILL: begin
                if (acc) begin
                    cnt_nxt = cyc_cnt + CNT_ONE;
                    if (cyc_cnt == D_LAST) state_nxt = S_RUN;
                end
            end
            S_RUN: begin
                if (resync) begin
                    cnt_nxt   = CNT_ONE;
                    state_nxt = (D == 1) ? S_RUN : S_FILL;
                end else if (run_beat) begin
                    cnt_nxt = cyc_cnt + CNT_ONE;   // natural wrap at CPF
                end else if (flush_beat) begin
                    if (D == 1) begin
                        cnt_nxt   = '0;
                        state_nxt = S_IDLE;
                    end else begin
                        cnt_nxt   = CNT_ONE;
                        state_nxt = S_FLUSH;
                    end
                end
            end
            S_FLUSH: begin
                if (cyc_cnt == D_LAST) begin
                    cnt_nxt   = '0;
                    state_nxt = S_IDLE;
                end else begin
                    cnt_nxt = cyc_cnt + CNT_ONE;
                end
            end
            default: begin
                cnt_nxt   = '0;
                state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state      <= S_IDLE;
            cyc_cnt    <= '0;
            dout_valid <= 1'b0;
            dout_sop   <= 1'b0;
            err_sop    <= 1'b0;
        end else begin
            state      <= state_nxt;
            cyc_cnt    <= cnt_nxt;
            dout_valid <= run_beat || flush_beat;
            dout_sop   <= run_beat && (cyc_cnt == D_IDX);
            err_sop    <= resync || miss_sop;
        end
    end

`ifdef FFT_CTRL_STAT_EN
    localparam logic [CW-1:0] CNT_LAST = CW'(CPF - 1);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            frame_cnt <= '0;
            err_cnt   <= '0;
        end else begin
            if (run_beat && (cyc_cnt == CNT_LAST)) frame_cnt <= frame_cnt + 16'd1;
            if ((resync || miss_sop) && (err_cnt != 8'hFF)) err_cnt <= err_cnt + 8'd1;
        end
    end
`endif

endmodule

// File: tb/tb_bf2_stage_ctrl.sv
module tb_bf2_stage_ctrl;

    localparam int N_POINT     = 512;
    localparam int LANES       = 16;
    localparam int STAGE_SHIFT = 3;
    localparam int CPF         = N_POINT / LANES;
    localparam int CW          = $clog2(CPF);
    localparam int D           = 1 << STAGE_SHIFT;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_FILL = 2'd1;

    // ---------------- clock / reset ----------------
    logic          clk = 1'b0;
    logic          rstn = 1'b0;
    logic          din_valid = 1'b0;
    logic          din_sop = 1'b0;
    logic          din_ready;
    logic          bf_en;
    logic          buf_sel;
    logic [CW-1:0] cyc_cnt;
    logic          dout_valid;
    logic          dout_sop;
    logic          err_sop;
    logic [1:0]    state_dbg;
`ifdef FFT_CTRL_STAT_EN
    logic [15:0]   frame_cnt;
    logic [7:0]    err_cnt;
`endif

    always #5 clk = ~clk;

    bf2_stage_ctrl #(
        .N_POINT    (N_POINT),
        .LANES      (LANES),
        .STAGE_SHIFT(STAGE_SHIFT)
    ) dut (
        .clk       (clk),
        .rstn      (rstn),
        .din_valid (din_valid),
        .din_sop   (din_sop),
        .din_ready (din_ready),
        .bf_en     (bf_en),
        .buf_sel   (buf_sel),
        .cyc_cnt   (cyc_cnt),
        .dout_valid(dout_valid),
        .dout_sop  (dout_sop),
        .err_sop   (err_sop),
`ifdef FFT_CTRL_STAT_EN
        .frame_cnt (frame_cnt),
        .err_cnt   (err_cnt),
`endif
        .state_dbg (state_dbg)
    );

    // ---------------- scoreboard ----------------
    // Expected {err_sop, dout_sop, dout_valid} for the cycle after each beat.
    logic [2:0] exp_q[$];
    int n_checks = 0;
    int n_pass   = 0;

    // Reference model: a stream described by position in frame.
    int m_pos;       // index of the next accepted beat within the frame
    bit m_active;    // a stream is in progress
    bit m_filled;    // the first D beats of the stream have been seen
    int m_flush;     // internal drain beats still to come
    int m_errs;
    int m_frames;
    int m_outs;

    // Observed statistics for scenario checks.
    int cyc_no = 0;
    int st_dv, st_bf, st_rdy_low, st_err, run_len, max_run;
    int sop_cyc[$];

    task automatic model_reset();
        m_pos = 0; m_active = 0; m_filled = 0; m_flush = 0;
        m_errs = 0; m_frames = 0; m_outs = 0;
        exp_q.delete();
    endtask

    task automatic clear_stats();
        st_dv = 0; st_bf = 0; st_rdy_low = 0; st_err = 0;
        run_len = 0; max_run = 0;
        sop_cyc.delete();
    endtask

    task automatic apply_reset();
        rstn = 1'b0; din_valid = 1'b0; din_sop = 1'b0;
        repeat (2) @(negedge clk);
        model_reset();
        rstn = 1'b1;
    endtask

    // ---------------- driver + reference check per cycle ----------------
    task automatic drive(input bit v, input bit s);
        logic [2:0] exp_reg;
        logic [2:0] nxt;
        bit e_ready, e_bf, boundary, pre_flush, beat_now;
        int e_cyc;
        @(negedge clk);
        din_valid = v;
        din_sop   = s;
        #1;
        exp_reg = (exp_q.size() > 0) ? exp_q.pop_front() : 3'b000;
        n_checks++;
        if ({err_sop, dout_sop, dout_valid} !== exp_reg)
            $display("FAIL regout cyc %0d: got %b expected %b", cyc_no, {err_sop, dout_sop, dout_valid}, exp_reg);
        else n_pass++;

        pre_flush = (m_flush > 0);
        boundary  = m_active && m_filled && (m_pos == 0);
        e_cyc     = pre_flush ? (D - m_flush) : (m_active ? m_pos : 0);
        e_ready   = !pre_flush && !(boundary && !v);
        beat_now  = (v && e_ready) || pre_flush || boundary;
        nxt  = 3'b000;
        e_bf = 1'b0;

        if (pre_flush) begin
            nxt[0] = 1'b1;
            m_flush--;
        end else if (!m_active) begin
            if (v && s) begin
                m_active = 1; m_pos = 1; m_filled = (D == 1);
            end
        end else if (!m_filled) begin
            if (v) begin
                m_pos++;
                if (m_pos == D) m_filled = 1;
            end
        end else if (m_pos == 0) begin
            if (v && s) begin
                nxt[0] = 1'b1;
                m_pos = 1;
            end else begin
                nxt[0] = 1'b1;
                nxt[2] = v;
                if (v) m_errs++;
                m_flush = D - 1; m_active = 0; m_filled = 0;
            end
        end else if (v && s) begin
            nxt[2] = 1'b1;
            m_errs++;
            m_pos = 1; m_filled = (D == 1);
        end else if (v) begin
            nxt[0] = 1'b1;
            e_bf   = ((m_pos / D) % 2) == 1;
            nxt[1] = (m_pos == D);
            m_pos  = (m_pos + 1) % CPF;
            if (m_pos == 0) m_frames++;
        end
        if (nxt[0]) m_outs++;
        exp_q.push_back(nxt);

        n_checks++;
        if (din_ready !== e_ready) $display("FAIL din_ready cyc %0d: got %b expected %b", cyc_no, din_ready, e_ready);
        else n_pass++;
        n_checks++;
        if (bf_en !== e_bf) $display("FAIL bf_en cyc %0d: got %b expected %b", cyc_no, bf_en, e_bf);
        else n_pass++;
        n_checks++;
        if (int'(cyc_cnt) !== e_cyc) $display("FAIL cyc_cnt cyc %0d: got %0d expected %0d", cyc_no, cyc_cnt, e_cyc);
        else n_pass++;
        if (beat_now) begin
            n_checks++;
            if (buf_sel !== e_bf) $display("FAIL buf_sel cyc %0d: got %b expected %b", cyc_no, buf_sel, e_bf);
            else n_pass++;
        end

        st_dv      += int'(dout_valid);
        st_err     += int'(err_sop);
        st_bf      += int'(bf_en);
        st_rdy_low += int'(!din_ready);
        run_len     = dout_valid ? run_len + 1 : 0;
        if (run_len > max_run) max_run = run_len;
        if (dout_sop) sop_cyc.push_back(cyc_no);
        cyc_no++;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rstn = 1'b0; din_valid = 1'b1; din_sop = 1'b1;
        #2;
        n_checks++;
        if ({bf_en, buf_sel, dout_valid, dout_sop, err_sop} !== 5'b0)
            $display("FAIL reset_outs: got %b expected 00000", {bf_en, buf_sel, dout_valid, dout_sop, err_sop});
        else n_pass++;
        n_checks++;
        if (cyc_cnt !== '0 || state_dbg !== ST_IDLE || din_ready !== 1'b1)
            $display("FAIL reset_state: cyc %0d state %0d ready %b expected 0 0 1", cyc_cnt, state_dbg, din_ready);
        else n_pass++;
`ifdef FFT_CTRL_STAT_EN
        n_checks++;
        if (frame_cnt !== 16'd0 || err_cnt !== 8'd0)
            $display("FAIL reset_stats: frame %0d err %0d expected 0 0", frame_cnt, err_cnt);
        else n_pass++;
`endif
        apply_reset();
    endtask

    task automatic test_single_frame();
        int start;
        logic [31:0] bf_vec;
        clear_stats();
        start = cyc_no;
        bf_vec = '0;
        for (int b = 0; b < CPF; b++) begin
            drive(1'b1, b == 0);
            bf_vec[b] = bf_en;
        end
        repeat (12) drive(1'b0, 1'b0);
        n_checks++;
        if (bf_vec !== 32'hFF00_FF00) $display("FAIL frame_bf_pattern: got %h expected ff00ff00", bf_vec);
        else n_pass++;
        n_checks++;
        if (st_dv !== 32 || max_run !== 32)
            $display("FAIL frame_dout_count: got %0d run %0d expected 32 32", st_dv, max_run);
        else n_pass++;
        n_checks++;
        if (sop_cyc.size() !== 1 || sop_cyc[0] !== start + D + 1)
            $display("FAIL frame_sop_time: count %0d first %0d expected 1 at %0d", sop_cyc.size(),
                     (sop_cyc.size() > 0) ? sop_cyc[0] : -1, start + D + 1);
        else n_pass++;
        n_checks++;
        if (st_rdy_low !== D) $display("FAIL frame_flush_ready: got %0d expected %0d", st_rdy_low, D);
        else n_pass++;
        n_checks++;
        if (state_dbg !== ST_IDLE) $display("FAIL frame_end_idle: got %0d expected 0", state_dbg);
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        clear_stats();
        for (int b = 0; b < 2 * CPF; b++) drive(1'b1, (b % CPF) == 0);
        repeat (12) drive(1'b0, 1'b0);
        n_checks++;
        if (st_dv !== 64 || max_run !== 64)
            $display("FAIL b2b_dout_run: got %0d run %0d expected 64 64", st_dv, max_run);
        else n_pass++;
        n_checks++;
        if (sop_cyc.size() !== 2 || sop_cyc[1] - sop_cyc[0] !== CPF)
            $display("FAIL b2b_sop_spacing: count %0d expected 2 spaced %0d", sop_cyc.size(), CPF);
        else n_pass++;
        n_checks++;
        if (st_bf !== 32 || st_rdy_low !== D || st_err !== 0)
            $display("FAIL b2b_counts: bf %0d rdy_low %0d err %0d expected 32 %0d 0", st_bf, st_rdy_low, D, st_err);
        else n_pass++;
    endtask

    task automatic test_gaps();
        clear_stats();
        for (int b = 0; b < CPF; b++) begin
            if (b == 5 || b == 20) begin
                drive(1'b0, 1'b0);
                n_checks++;
                if (int'(cyc_cnt) !== b || bf_en !== 1'b0)
                    $display("FAIL gap_hold_%0d: cyc %0d bf %b expected %0d 0", b, cyc_cnt, bf_en, b);
                else n_pass++;
            end
            drive(1'b1, b == 0);
            if (b == 5 || b == 20) begin
                n_checks++;
                if (int'(cyc_cnt) !== b || dout_valid !== 1'b0)
                    $display("FAIL gap_after_%0d: cyc %0d dout_valid %b expected %0d 0", b, cyc_cnt, dout_valid, b);
                else n_pass++;
            end
        end
        repeat (12) drive(1'b0, 1'b0);
        n_checks++;
        if (st_dv !== 32) $display("FAIL gap_dout_count: got %0d expected 32", st_dv);
        else n_pass++;
    endtask

    task automatic test_resync();
        int r;
        for (int b = 0; b < 13; b++) drive(1'b1, b == 0);
        clear_stats();
        r = cyc_no;
        drive(1'b1, 1'b1);
        n_checks++;
        if (int'(cyc_cnt) !== 13) $display("FAIL resync_pos: got %0d expected 13", cyc_cnt);
        else n_pass++;
        clear_stats();
        drive(1'b1, 1'b0);
        n_checks++;
        if (err_sop !== 1'b1 || int'(cyc_cnt) !== 1 || state_dbg !== ST_FILL)
            $display("FAIL resync_state: err %b cyc %0d state %0d expected 1 1 1", err_sop, cyc_cnt, state_dbg);
        else n_pass++;
        for (int b = 2; b < CPF; b++) drive(1'b1, 1'b0);
        repeat (12) drive(1'b0, 1'b0);
        n_checks++;
        if (st_err !== 1) $display("FAIL resync_err_pulse: got %0d expected 1", st_err);
        else n_pass++;
        n_checks++;
        if (sop_cyc.size() !== 1 || sop_cyc[0] !== r + D + 1)
            $display("FAIL resync_sop_time: count %0d expected 1 at %0d", sop_cyc.size(), r + D + 1);
        else n_pass++;
        n_checks++;
        if (st_dv !== 32 || max_run !== 32)
            $display("FAIL resync_dout: got %0d run %0d expected 32 32", st_dv, max_run);
        else n_pass++;
    endtask

    task automatic test_reset_mid();
        for (int b = 0; b < 21; b++) drive(1'b1, b == 0);
        n_checks++;
        if (int'(cyc_cnt) !== 20 || dout_valid !== 1'b1)
            $display("FAIL midrst_pre: cyc %0d dout_valid %b expected 20 1", cyc_cnt, dout_valid);
        else n_pass++;
        #1 rstn = 1'b0;
        #1;
        n_checks++;
        if ({bf_en, buf_sel, dout_valid, dout_sop, err_sop} !== 5'b0 || cyc_cnt !== '0 || state_dbg !== ST_IDLE)
            $display("FAIL midrst_async: outs %b cyc %0d state %0d expected 00000 0 0",
                     {bf_en, buf_sel, dout_valid, dout_sop, err_sop}, cyc_cnt, state_dbg);
        else n_pass++;
        @(negedge clk);
        din_valid = 1'b0; din_sop = 1'b0;
        @(negedge clk);
        model_reset();
        rstn = 1'b1;
        test_single_frame();
    endtask

    task automatic test_random();
        int kind, e0, o0;
        clear_stats();
        e0 = m_errs; o0 = m_outs;
        for (int f = 0; f < 24; f++) begin
            kind = $urandom_range(0, 9);
            for (int b = 0; b < CPF; b++) begin
                if (b != 0 && $urandom_range(0, 5) == 0) drive(1'b0, 1'b0);
                drive(1'b1, (b == 0 && kind != 1) || (kind == 0 && b == 17));
            end
            repeat ($urandom_range(0, 12)) drive(1'b0, 1'b0);
        end
        repeat (12) drive(1'b0, 1'b0);
        n_checks++;
        if (st_err !== m_errs - e0) $display("FAIL rand_err_total: got %0d expected %0d", st_err, m_errs - e0);
        else n_pass++;
        n_checks++;
        if (st_dv !== m_outs - o0) $display("FAIL rand_dout_total: got %0d expected %0d", st_dv, m_outs - o0);
        else n_pass++;
    endtask

`ifdef FFT_CTRL_STAT_EN
    task automatic test_stats();
        apply_reset();
        for (int b = 0; b < 13; b++) drive(1'b1, b == 0);
        drive(1'b1, 1'b1);
        for (int b = 1; b < 13; b++) drive(1'b1, 1'b0);
        drive(1'b1, 1'b1);
        for (int b = 1; b < CPF; b++) drive(1'b1, 1'b0);
        for (int b = 0; b < 2 * CPF; b++) drive(1'b1, (b % CPF) == 0);
        repeat (12) drive(1'b0, 1'b0);
        n_checks++;
        if (frame_cnt !== 16'd3 || err_cnt !== 8'd2)
            $display("FAIL stats_counts: frame %0d err %0d expected 3 2", frame_cnt, err_cnt);
        else n_pass++;
        drive(1'b1, 1'b1);
        for (int k = 0; k < 300; k++) begin
            for (int b = 1; b < D; b++) drive(1'b1, 1'b0);
            drive(1'b1, 1'b1);
        end
        repeat (4) drive(1'b0, 1'b0);
        n_checks++;
        if (err_cnt !== 8'd255 || m_errs !== 302)
            $display("FAIL stats_saturate: err_cnt %0d model %0d expected 255 302", err_cnt, m_errs);
        else n_pass++;
    endtask
`endif

    // ---------------- sequence + final report ----------------
    initial begin
        model_reset();
        clear_stats();
        test_reset();
        test_single_frame();
        test_back_to_back();
        test_gaps();
        test_resync();
        test_reset_mid();
        test_random();
`ifdef FFT_CTRL_STAT_EN
        test_stats();
`endif
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
